// File: rtl/rx_cmd_pkg.sv
// Shared command codes and FSM encodings for the host command path.
// The transmit side and any host-side model reuse the same byte codes.
package rx_cmd_pkg;

  localparam logic [7:0] CMD_LOAD_A  = 8'h01;
  localparam logic [7:0] CMD_LOAD_B  = 8'h02;
  localparam logic [7:0] CMD_LOAD_OP = 8'h03;
  localparam logic [7:0] CMD_DISPLAY = 8'h04;

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_DATA = 1'b1
  } state_e;

  // Register a latched LOAD command will write when its payload arrives.
  typedef enum logic [1:0] {
    TGT_A  = 2'd0,
    TGT_B  = 2'd1,
    TGT_OP = 2'd2
  } tgt_e;

endpackage

// File: rtl/rx_cmd_controller.sv
// Decodes host command/payload byte frames into ALU operand/opcode registers; all outputs registered (payload visible 1 cycle after its strobe).
// Display requests pulse 2 cycles after DISPLAY when idle; a request is held pending while display_busy and merged with repeats.
module rx_cmd_controller
  import rx_cmd_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done_pulse,
  input  logic              display_busy,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              display_cmd_pulse,
  output logic              cmd_error_pulse
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  tgt_e               tgt_q, tgt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               pending_q, pending_d;
  logic               disp_q, disp_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  opa_q, opa_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic [OP_W-1:0]    opc_q, opc_d;

  logic               is_load, is_disp;
  tgt_e               rx_tgt;
  logic               pend_set;
  logic               timeout_hit;

  always_comb begin : decode
    is_load = 1'b0;
    is_disp = 1'b0;
    rx_tgt  = TGT_A;
    case (rx_data)
      DATA_W'(CMD_LOAD_A):  begin is_load = 1'b1; rx_tgt = TGT_A;  end
      DATA_W'(CMD_LOAD_B):  begin is_load = 1'b1; rx_tgt = TGT_B;  end
      DATA_W'(CMD_LOAD_OP): begin is_load = 1'b1; rx_tgt = TGT_OP; end
      DATA_W'(CMD_DISPLAY): is_disp = 1'b1;
      default:              ;
    endcase
  end

  assign timeout_hit = (timer_q == TMR_LAST);

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (rx_done_pulse && is_load) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (rx_done_pulse || timeout_hit) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    tgt_d    = tgt_q;
    timer_d  = timer_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    err_d    = 1'b0;
    pend_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_done_pulse) begin
          if (is_load) begin
            tgt_d   = rx_tgt;
            timer_d = '0;
          end else if (is_disp) begin
            pend_set = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT_DATA: begin
        // Any byte here is payload, even one that looks like a command code.
        if (rx_done_pulse) begin
          case (tgt_q)
            TGT_A:   opa_d = rx_data;
            TGT_B:   opb_d = rx_data;
            TGT_OP:  opc_d = rx_data[OP_W-1:0];
            default: ;
          endcase
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: ;
    endcase

    // Gate on disp_q so a pulse never stretches; a same-cycle new request keeps pending set.
    disp_d    = pending_q && !display_busy && !disp_q;
    pending_d = pend_set || (pending_q && !disp_d);
  end

  always_ff @(posedge clk) begin : data_regs
    if (reset) begin
      tgt_q     <= TGT_A;
      timer_q   <= '0;
      pending_q <= 1'b0;
      disp_q    <= 1'b0;
      err_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
    end else begin
      tgt_q     <= tgt_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      err_q     <= err_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opc_q     <= opc_d;
    end
  end

  assign alu_operand_a     = opa_q;
  assign alu_operand_b     = opb_q;
  assign alu_opcode        = opc_q;
  assign display_cmd_pulse = disp_q;
  assign cmd_error_pulse   = err_q;

endmodule

// File: tb/tb_rx_cmd_controller.sv
// Bench for rx_cmd_controller: directed vector table, hand-written multi-cycle sequences,
// then random traffic compared cycle by cycle against an event-level reference model.
module tb_rx_cmd_controller;
  import rx_cmd_pkg::*;

  localparam int DATA_W = 8;
  localparam int OP_W   = 6;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_done_pulse = 1'b0;
  logic              display_busy = 1'b0;
  logic [DATA_W-1:0] alu_operand_a;
  logic [DATA_W-1:0] alu_operand_b;
  logic [OP_W-1:0]   alu_opcode;
  logic              display_cmd_pulse;
  logic              cmd_error_pulse;

  rx_cmd_controller #(
    .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_pulse(rx_done_pulse),
    .display_busy(display_busy), .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b), .alu_opcode(alu_opcode),
    .display_cmd_pulse(display_cmd_pulse), .cmd_error_pulse(cmd_error_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the cycle a LOAD arrived and times out by elapsed cycle count.
  int       m_cyc = 0;
  bit       m_wait = 0;
  int       m_cmd = 0;
  int       m_since = 0;
  bit       m_pend = 0;
  bit [7:0] m_a = 0, m_b = 0;
  bit [5:0] m_op = 0;
  bit       m_disp = 0, m_err = 0;

  task automatic model_edge();
    bit fire, set_pend;
    m_cyc++;
    if (reset) begin
      m_wait = 0; m_pend = 0; m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_err = 0;
      return;
    end
    fire = m_pend && !display_busy && !m_disp;
    set_pend = 0;
    m_err = 0;
    if (m_wait) begin
      if (rx_done_pulse) begin
        if (m_cmd == int'(CMD_LOAD_A)) m_a = rx_data;
        else if (m_cmd == int'(CMD_LOAD_B)) m_b = rx_data;
        else m_op = rx_data[5:0];
        m_wait = 0;
      end else if (m_cyc - m_since == TMO) begin
        m_err = 1;
        m_wait = 0;
      end
    end else if (rx_done_pulse) begin
      if (rx_data inside {CMD_LOAD_A, CMD_LOAD_B, CMD_LOAD_OP}) begin
        m_wait = 1; m_cmd = int'(rx_data); m_since = m_cyc;
      end else if (rx_data == CMD_DISPLAY) begin
        set_pend = 1;
      end else begin
        m_err = 1;
      end
    end
    m_pend = set_pend || (m_pend && !fire);
    m_disp = fire;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit v, bit [7:0] d, bit b);
    reset = r; rx_done_pulse = v; rx_data = d; display_busy = b;
    tick();
  endtask

  task automatic check_all(string tag, bit [7:0] a, bit [7:0] b, bit [5:0] op, bit disp, bit err);
    check({tag, ".a"},    int'(alu_operand_a),     int'(a));
    check({tag, ".b"},    int'(alu_operand_b),     int'(b));
    check({tag, ".op"},   int'(alu_opcode),        int'(op));
    check({tag, ".disp"}, int'(display_cmd_pulse), int'(disp));
    check({tag, ".err"},  int'(cmd_error_pulse),   int'(err));
  endtask

  typedef struct {
    bit       rst, vld, busy;
    bit [7:0] dat;
    bit [7:0] a, b;
    bit [5:0] op;
    bit       disp, err;
  } vec_t;

  vec_t     tbl[$];
  bit [7:0] ea = 0, eb = 0;
  bit [5:0] eo = 0;

  function automatic void add(bit rst, bit vld, bit [7:0] dat, bit busy, bit disp, bit err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.busy = busy;
    v.a = ea; v.b = eb; v.op = eo; v.disp = disp; v.err = err;
    tbl.push_back(v);
  endfunction

  function automatic void gap(int n);
    for (int i = 0; i < n; i++) add(0, 0, 8'h00, 0, 0, 0);
  endfunction

  int       quiet;
  bit       r_rst, r_vld, r_busy;
  bit [7:0] r_dat;

  initial begin
    // Directed table: expected register values are what each row's edge should leave behind.
    add(1, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h01, 0, 0, 0);
    ea = 8'h2A; add(0, 1, 8'h2A, 0, 0, 0); gap(5);
    add(0, 1, 8'h02, 0, 0, 0);
    eb = 8'h15; add(0, 1, 8'h15, 0, 0, 0); gap(5);
    add(0, 1, 8'h03, 0, 0, 0);
    eo = 6'h20; add(0, 1, 8'hE0, 0, 0, 0); gap(5);
    add(0, 1, 8'h04, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0);
    gap(2);
    add(0, 1, 8'h7F, 0, 0, 1);
    gap(1);
    add(0, 1, 8'h02, 0, 0, 0);
    eb = 8'h04; add(0, 1, 8'h04, 0, 0, 0); gap(3);
    add(0, 1, 8'h03, 0, 0, 0);
    eo = 6'h3F; add(0, 1, 8'hFF, 0, 0, 0); gap(1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].busy);
      check_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].disp, tbl[i].err);
    end

    // Busy transmit path: two DISPLAYs merge into one pulse right after busy drops.
    drive(0, 1, 8'h04, 1);
    check("busy.disp0", int'(display_cmd_pulse), 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1);
    drive(0, 1, 8'h04, 1);
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 8'h00, 1);
      check("busy.hold", int'(display_cmd_pulse), 0);
    end
    drive(0, 0, 8'h00, 0);
    check("busy.release", int'(display_cmd_pulse), 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00, 0);
      check("busy.single", int'(display_cmd_pulse), 0);
    end

    // Payload timeout: error after TMO waiting cycles, operand untouched, then back in idle.
    drive(0, 1, 8'h01, 0);
    for (int i = 0; i < TMO - 1; i++) begin
      drive(0, 0, 8'h00, 0);
      check("tmo.early", int'(cmd_error_pulse), 0);
    end
    drive(0, 0, 8'h00, 0);
    check_all("tmo.hit", 8'h2A, 8'h04, 6'h3F, 0, 1);
    drive(0, 0, 8'h00, 0);
    check("tmo.once", int'(cmd_error_pulse), 0);
    drive(0, 1, 8'h01, 0);
    drive(0, 1, 8'h04, 0);
    check("tmo.reload", int'(alu_operand_a), 8'h04);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 0);
      check("tmo.nodisp", int'(display_cmd_pulse), 0);
    end

    // Payload on the very cycle the timeout would fire: payload wins.
    drive(0, 1, 8'h02, 0);
    for (int i = 0; i < TMO - 1; i++) drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h5A, 0);
    check_all("edge.win", 8'h04, 8'h5A, 6'h3F, 0, 0);
    drive(0, 0, 8'h00, 0);
    check("edge.noerr", int'(cmd_error_pulse), 0);

    // Reset mid-frame with a pending display drops both.
    drive(0, 1, 8'h04, 1);
    drive(0, 1, 8'h01, 1);
    drive(1, 0, 8'h00, 1);
    check_all("rst", 8'h00, 8'h00, 6'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 8'h00, 0);
      check("rst.nodisp", int'(display_cmd_pulse), 0);
    end

    // Random traffic against the model.
    quiet = 0;
    r_busy = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 8 == 0) r_busy = !r_busy;
      if (quiet > 0) begin
        quiet--;
        r_vld = 0;
      end else begin
        if ($urandom % 40 == 0) quiet = $urandom_range(10, 24);
        r_vld = ($urandom % 4 == 0);
      end
      r_dat = ($urandom % 5 < 3) ? 8'($urandom_range(1, 4)) : 8'($urandom);
      r_rst = ($urandom % 700 == 0);
      drive(r_rst, r_vld, r_dat, r_busy);
      check_all("rnd", m_a, m_b, m_op, m_disp, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_cmd_controller.md
Name: rx_cmd_controller

Overview:
Command decoder and configuration FSM between uart_rx and the ALU.
- Parses host byte frames of the form command byte, optionally followed by one payload byte.
- Loads the ALU operand and opcode registers from those frames.
- Schedules display requests toward tx_controller, holding a request while the transmit path is busy.
- Pairs with tx_controller to close the host -> ALU -> host loop.

Parameters:
DATA_W, 8, operand and UART byte width
OP_W, 6, ALU opcode width; LOAD_OP keeps payload bits [OP_W-1:0]
TIMEOUT_CYCLES, 1000000, max clk cycles to wait for a payload byte before aborting (must be >= 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  byte from uart_rx, valid only when rx_done_pulse=1
rx_done_pulse  in  1  one-cycle strobe: new byte received
display_busy  in  1  transmit path busy (tied to uart_tx busy flag)
alu_operand_a  out  DATA_W  registered operand A
alu_operand_b  out  DATA_W  registered operand B
alu_opcode  out  OP_W  registered ALU opcode
display_cmd_pulse  out  1  registered one-cycle request to tx_controller
cmd_error_pulse  out  1  registered one-cycle strobe: unknown command or payload timeout

Behaviour:
- Clock and reset: one clock clk. reset is synchronous and active-high.
- On reset, all outputs are 0, state is S_IDLE, pending flag is 0 and the timer is 0. Reset mid-frame discards the frame and any pending display request.
- Command codes: 0x01 LOAD_A, 0x02 LOAD_B, 0x03 LOAD_OP (each takes 1 payload byte); 0x04 DISPLAY (no payload). Any other code is illegal.
- States:
  - S_IDLE: waits for rx_done_pulse.
  - S_WAIT_DATA: latched command awaits its payload.
- S_IDLE + rx_done_pulse:
  - LOAD_x: latch the command, clear the timer, go to S_WAIT_DATA.
  - DISPLAY: set pending, stay in S_IDLE.
  - Illegal code: cmd_error_pulse=1 on the next cycle, stay in S_IDLE.
- S_WAIT_DATA + rx_done_pulse:
  - The byte is always payload, even if it equals a command code.
  - The target register updates on that clock edge and is visible the following cycle.
  - Return to S_IDLE.
- S_WAIT_DATA without rx_done_pulse:
  - The timer increments each cycle.
  - When timer == TIMEOUT_CYCLES-1: go to S_IDLE, cmd_error_pulse=1 for one cycle, registers unchanged.
  - If rx_done_pulse coincides with the timeout cycle, the payload wins: register is written, no error.
- Timer width is $clog2(TIMEOUT_CYCLES). The timer never wraps, because it is cleared on entry to S_WAIT_DATA.
- Display scheduling:
  - When pending=1 && display_busy=0 && display_cmd_pulse=0: set display_cmd_pulse=1 for exactly one cycle and clear pending.
  - When idle, latency from the DISPLAY rx_done_pulse to display_cmd_pulse is 2 cycles.
  - While display_busy=1, pending holds indefinitely.
  - A second DISPLAY received while pending=1 merges with it, giving only one pulse.
  - If a set and a clear of pending occur in the same cycle, the set wins.
- LOAD_OP writes rx_data[OP_W-1:0]; upper bits are ignored.
- Operand and opcode registers hold their value until rewritten. They are not cleared by errors.
- cmd_error_pulse and display_cmd_pulse are never asserted for more than one consecutive cycle per event.

Decomposition:
- Shared package rx_cmd_pkg holds:
  - command codes CMD_LOAD_A, CMD_LOAD_B, CMD_LOAD_OP, CMD_DISPLAY;
  - state encodings S_IDLE and S_WAIT_DATA.
- tx_controller and the testbench reuse the command codes from the same package.
- No sub-module: the timer and pending latch are small enough to stay inline in a single module.

Test Plan:
1. Bytes 0x01,0x2A then 0x02,0x15 then 0x03,0xE0, with gaps of 5 cycles -> alu_operand_a=0x2A, alu_operand_b=0x15, alu_opcode=6'h20, no errors.
2. Byte 0x04 with display_busy=0 -> display_cmd_pulse high exactly one cycle, 2 cycles after rx_done_pulse.
3. display_busy=1, send 0x04 twice, release busy after 40 cycles -> exactly one display_cmd_pulse, 1 cycle after busy falls.
4. TIMEOUT_CYCLES=16, send 0x01 and no payload -> cmd_error_pulse after 16 cycles, back to S_IDLE, alu_operand_a unchanged. Then send 0x01,0x04 -> alu_operand_a=0x04 and no display pulse.
5. Byte 0x7F -> cmd_error_pulse for one cycle, all registers unchanged.
6. reset asserted in S_WAIT_DATA with pending=1 -> all outputs 0 next cycle, no display_cmd_pulse afterwards. Also: payload arriving exactly on the timeout cycle -> register written, no cmd_error_pulse.
